_kbd_fifo: RTL and testbench

_KBD_FIFO -- requirements
Module: _kbd_fifo

---
 rtl/_kbd_fifo.sv | 75 +++++++
 tb/tb__kbd_fifo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/_kbd_fifo.sv
// _kbd_fifo: keyboard scan-code FIFO feeding the memory-mapped KBD register.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   key_valid, key_code   upstream push strobe and signed scan code (0 = no key)
//   ack                   consumer pop strobe for the head entry
//   clr_ovf               clears the sticky overflow flag
//   out                   head entry, 0 while empty
//   empty, full, count    occupancy status from the count register
//   ovf                   sticky flag: a key was dropped while full
module _kbd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      key_valid,
    input  logic signed [WIDTH-1:0]   key_code,
    input  logic                      ack,
    input  logic                      clr_ovf,
    output logic signed [WIDTH-1:0]   out,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, wr_en, drop;

    always_comb begin
        push    = key_valid && (key_code != '0);
        pop     = ack && (count_q != '0);
        // When full, a push only lands if the head is popped on the same edge;
        // then wp == rp and the freed slot is exactly the one being written.
        wr_en   = push && ((count_q != (AW+1)'(DEPTH)) || pop);
        drop    = push && !wr_en;
        wp_d    = wr_en ? wp_q + AW'(1) : wp_q;
        rp_d    = pop ? rp_q + AW'(1) : rp_q;
        count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        // A drop in the same cycle as clr_ovf keeps the flag set.
        ovf_d   = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; stale contents are hidden by forcing out to 0 when empty.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en)
            mem_q[wp_q] <= key_code;
    end

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == (AW+1)'(DEPTH));
        count = count_q;
        ovf   = ovf_q;
        out   = empty ? '0 : $signed(mem_q[rp_q]);
    end
endmodule

// File: tb/tb__kbd_fifo.sv
module tb__kbd_fifo;
    logic               clk = 1'b0;
    logic               reset_n;
    logic               key_valid, ack, clr_ovf;
    logic signed [15:0] key_code;
    logic signed [15:0] out;
    logic               empty, full, ovf;
    logic [3:0]         count;
    int                 tests = 0;
    int                 fails = 0;
    logic [15:0]        exp_q [$];
    logic [15:0]        data [12];

    _kbd_fifo #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
        .ack(ack), .clr_ovf(clr_ovf), .out(out), .empty(empty), .full(full),
        .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] code, input logic a, input logic c);
        key_valid = v;
        key_code  = code;
        ack       = a;
        clr_ovf   = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = '0;
        ack       = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; key_valid = 1'b0; key_code = '0; ack = 1'b0; clr_ovf = 1'b0;
        #2;
        chk("rst_out", out, 16'h0);
        chk("rst_empty", 16'(empty), 16'd1);
        chk("rst_full", 16'(full), 16'd0);
        chk("rst_count", 16'(count), 16'd0);
        chk("rst_ovf", 16'(ovf), 16'd0);
        #10 reset_n = 1'b1;
        // single push / pop
        cyc(1, 16'h0041, 0, 0);
        chk("p1_out", out, 16'h0041);
        chk("p1_count", 16'(count), 16'd1);
        chk("p1_empty", 16'(empty), 16'd0);
        cyc(0, 0, 1, 0);
        chk("pop1_out", out, 16'h0);
        chk("pop1_empty", 16'(empty), 16'd1);
        // fill, overflow, drain
        for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 0, 0);
        chk("fill_full", 16'(full), 16'd1);
        chk("fill_count", 16'(count), 16'd8);
        chk("fill_ovf", 16'(ovf), 16'd0);
        cyc(1, 16'h0009, 0, 0);
        chk("drop_ovf", 16'(ovf), 16'd1);
        chk("drop_count", 16'(count), 16'd8);
        chk("drop_full", 16'(full), 16'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_out", out, 16'(i));
            cyc(0, 0, 1, 0);
        end
        chk("drain_empty", 16'(empty), 16'd1);
        chk("drain_out0", out, 16'h0);
        cyc(0, 0, 1, 0);
        chk("ack_empty_count", 16'(count), 16'd0);
        chk("ovf_sticky", 16'(ovf), 16'd1);
        cyc(0, 0, 0, 1);
        chk("clr_ovf", 16'(ovf), 16'd0);
        // full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 0, 0);
        cyc(1, 16'h0010, 1, 0);
        chk("fpp_count", 16'(count), 16'd8);
        chk("fpp_ovf", 16'(ovf), 16'd0);
        chk("fpp_out", out, 16'h0002);
        exp_q = '{16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8, 16'h10};
        foreach (exp_q[i]) begin
            chk("fpp_drain", out, exp_q[i]);
            cyc(0, 0, 1, 0);
        end
        chk("fpp_empty", 16'(empty), 16'd1);
        // empty with simultaneous push and pop; zero code ignored
        cyc(1, 16'h0020, 1, 0);
        chk("epp_count", 16'(count), 16'd1);
        chk("epp_out", out, 16'h0020);
        cyc(1, 16'h0000, 0, 0);
        chk("zero_count", 16'(count), 16'd1);
        cyc(0, 0, 1, 0);
        chk("epp_empty", 16'(empty), 16'd1);
        // interleaved pairs across pointer wrap
        data = '{16'h1111, 16'h8000, 16'h2222, 16'hFFFF, 16'h0001, 16'h7FFF,
                 16'h3333, 16'h8001, 16'h4444, 16'hFFFE, 16'h5555, 16'h00FF};
        cyc(1, data[0], 0, 0);
        for (int i = 1; i < 12; i++) begin
            chk("wrap_out", out, data[i-1]);
            cyc(1, data[i], 1, 0);
            chk("wrap_count", 16'(count), 16'd1);
        end
        chk("wrap_last", out, data[11]);
        cyc(0, 0, 1, 0);
        chk("wrap_empty", 16'(empty), 16'd1);
        // clr_ovf colliding with a drop: set wins
        for (int i = 1; i <= 8; i++) cyc(1, 16'(i + 16'h30), 0, 0);
        cyc(1, 16'h0099, 0, 1);
        chk("clr_drop_ovf", 16'(ovf), 16'd1);
        chk("clr_drop_count", 16'(count), 16'd8);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        chk("pre_rst_count", 16'(count), 16'd5);
        chk("pre_rst_out", out, 16'h0034);
        // asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", 16'(count), 16'd0);
        chk("arst_out", out, 16'h0);
        chk("arst_ovf", 16'(ovf), 16'd0);
        chk("arst_empty", 16'(empty), 16'd1);
        cyc(1, 16'h0077, 1, 0);
        chk("rst_push_ignored", 16'(count), 16'd0);
        #2 reset_n = 1'b1;
        cyc(1, 16'h0055, 0, 0);
        chk("post_rst_count", 16'(count), 16'd1);
        chk("post_rst_out", out, 16'h0055);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
